vsync_timing_decoder: RTL and testbench

- Receive-side counterpart of the vertical sync generator.
- Watches incoming active-low hsync/vsync on the system clock and measures frame period and vsync pulse width in lines.
- Declares lock after two identical consecutive frames, then regenerates yposition and an active-line flag.
- Used for loopback checking of the video timer and for downstream blocks slaved to an external sync source.

---
 rtl/vsync_timing_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_vsync_timing_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vsync_timing_decoder.sv
// Purpose : recovers vertical timing from incoming active-low hsync/vsync. It measures
//           the frame period and the vsync width in lines, locks after two identical
//           consecutive frames, and then regenerates yposition and an active-line flag.
// Latency : the registered outputs update on the same CLK edge that samples the input
//           edge into the hs/vs delay flops, so they are visible one cycle after that edge.
// Backpressure: none. Syncs are free-running, and the decoder never stalls its source.
//
// Ports:
//   CLK, RESET              system clock; synchronous active-high reset
//   hsync, vsync            active-low syncs, already in the CLK domain
//   BackPorch, ActiveVideo  vertical window: lines from the vsync release, and the active line count
//   TotalLines, SyncLines   locked frame period and vsync width, held while not locked
//   yposition, ActiveLine   active line index and active-region flag (only while locked)
//   Locked, FrameStart      lock flag; one-cycle pulse per vsync fall accepted into LOCKED
// Optional build macro VSYNC_DECODER_ERRCNT_EN adds LockLossCount, an 8-bit saturating
// count of transitions out of LOCKED.

module vsync_timing_decoder #(
  parameter int yresolution = 10
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic [yresolution-1:0] BackPorch,
  input  logic [yresolution-1:0] ActiveVideo,
  output logic [yresolution-1:0] TotalLines,
  output logic [yresolution-1:0] SyncLines,
  output logic [yresolution-1:0] yposition,
  output logic                   ActiveLine,
  output logic                   Locked,
  output logic                   FrameStart
`ifdef VSYNC_DECODER_ERRCNT_EN
  ,
  output logic [7:0]             LockLossCount
`endif
);

  localparam logic [yresolution-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  // Saturating increment shared by all line counters.
  function automatic logic [yresolution-1:0] sat_inc(input logic [yresolution-1:0] v,
                                                     input logic                   inc);
    return (inc && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

  state_t                 state_q, state_d;
  logic                   hs_dly_q, vs_dly_q;
  logic [yresolution-1:0] lc_q, lc_d;
  logic [yresolution-1:0] sc_q, sc_d;
  logic [yresolution-1:0] rc_q, rc_d;
  logic [yresolution-1:0] meas_sync_q, meas_sync_d;
  logic [yresolution-1:0] prev_total_q, prev_total_d;
  logic [yresolution-1:0] prev_sync_q, prev_sync_d;
  logic [yresolution-1:0] total_q, total_d;
  logic [yresolution-1:0] sync_q, sync_d;
  logic [yresolution-1:0] ypos_q, ypos_d;
  logic                   locked_q, locked_d;
  logic                   active_q, active_d;
  logic                   fs_q, fs_d;

  logic                   line_tick, vs_fall, vs_rise;
  logic                   timeout, frame_match;
  logic [yresolution-1:0] meas_total;
  logic [yresolution:0]   rc_ext, win_lo, win_hi;

  assign line_tick = hs_dly_q & ~hsync;
  assign vs_fall   = vs_dly_q & ~vsync;
  assign vs_rise   = ~vs_dly_q & vsync;

  // Period of the frame that ends at this vsync fall. A coincident hsync tick belongs
  // to the ending frame, so it is folded in here before lc clears.
  assign meas_total  = sat_inc(lc_q, line_tick);
  assign frame_match = (meas_total == prev_total_q) && (meas_sync_q == prev_sync_q);
  // A saturated line counter means no vsync for a full counter range.
  assign timeout     = (lc_q == CNT_MAX) && (state_q != SEARCH);

  always_comb begin
    lc_d         = vs_fall ? '0 : sat_inc(lc_q, line_tick);
    sc_d         = vs_fall ? '0 : sat_inc(sc_q, line_tick & ~vsync);
    meas_sync_d  = vs_rise ? sat_inc(sc_q, line_tick) : meas_sync_q;
    // A tick coincident with the vsync release is not part of the region count.
    rc_d         = vs_rise ? '0 : sat_inc(rc_q, line_tick);

    state_d      = state_q;
    prev_total_d = prev_total_q;
    prev_sync_d  = prev_sync_q;
    total_d      = total_q;
    sync_d       = sync_q;

    // A vsync fall takes priority over a timeout in the same cycle.
    if (vs_fall) begin
      case (state_q)
        SEARCH: state_d = MEASURE;
        MEASURE: begin
          prev_total_d = meas_total;
          prev_sync_d  = meas_sync_q;
          state_d      = VERIFY;
        end
        VERIFY, LOCKED: begin
          if (frame_match) begin
            total_d = meas_total;
            sync_d  = meas_sync_q;
            state_d = LOCKED;
          end else begin
            prev_total_d = meas_total;
            prev_sync_d  = meas_sync_q;
            state_d      = VERIFY;
          end
        end
        default: state_d = SEARCH;
      endcase
    end else if (timeout) begin
      state_d = SEARCH;
    end

    locked_d = (state_d == LOCKED);
    fs_d     = vs_fall && (state_d == LOCKED);

    // The window compare uses one extra bit so BackPorch+ActiveVideo cannot wrap.
    rc_ext   = {1'b0, rc_d};
    win_lo   = {1'b0, BackPorch};
    win_hi   = {1'b0, BackPorch} + {1'b0, ActiveVideo};
    active_d = locked_d && (rc_ext >= win_lo) && (rc_ext < win_hi);
    ypos_d   = active_d ? (rc_d - BackPorch) : '0;
  end

`ifdef VSYNC_DECODER_ERRCNT_EN
  logic [7:0] llc_q, llc_d;

  always_comb begin
    llc_d = llc_q;
    if ((state_q == LOCKED) && (state_d != LOCKED) && (llc_q != 8'hFF)) begin
      llc_d = llc_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      llc_q <= 8'd0;
    end else begin
      llc_q <= llc_d;
    end
  end

  assign LockLossCount = llc_q;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= SEARCH;
      // The delay flops reset to the idle (high) level so that a sync already held low
      // at reset release is not seen as an edge.
      hs_dly_q     <= 1'b1;
      vs_dly_q     <= 1'b1;
      lc_q         <= '0;
      sc_q         <= '0;
      rc_q         <= '0;
      meas_sync_q  <= '0;
      prev_total_q <= '0;
      prev_sync_q  <= '0;
      total_q      <= '0;
      sync_q       <= '0;
      ypos_q       <= '0;
      locked_q     <= 1'b0;
      active_q     <= 1'b0;
      fs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_dly_q     <= hsync;
      vs_dly_q     <= vsync;
      lc_q         <= lc_d;
      sc_q         <= sc_d;
      rc_q         <= rc_d;
      meas_sync_q  <= meas_sync_d;
      prev_total_q <= prev_total_d;
      prev_sync_q  <= prev_sync_d;
      total_q      <= total_d;
      sync_q       <= sync_d;
      ypos_q       <= ypos_d;
      locked_q     <= locked_d;
      active_q     <= active_d;
      fs_q         <= fs_d;
    end
  end

  assign TotalLines = total_q;
  assign SyncLines  = sync_q;
  assign yposition  = ypos_q;
  assign ActiveLine = active_q;
  assign Locked     = locked_q;
  assign FrameStart = fs_q;

endmodule

// File: tb/tb_vsync_timing_decoder.sv
// Purpose : directed bench for vsync_timing_decoder with hand-computed expectations.
// Latency : outputs are sampled 1 ns after each rising CLK edge.
// Backpressure: not applicable.

module tb_vsync_timing_decoder;

  localparam int W = 10;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         hsync;
  logic         vsync;
  logic [W-1:0] BackPorch;
  logic [W-1:0] ActiveVideo;
  logic [W-1:0] TotalLines;
  logic [W-1:0] SyncLines;
  logic [W-1:0] yposition;
  logic         ActiveLine;
  logic         Locked;
  logic         FrameStart;
`ifdef VSYNC_DECODER_ERRCNT_EN
  logic [7:0]   LockLossCount;
`endif

  vsync_timing_decoder #(.yresolution(W)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .hsync        (hsync),
    .vsync        (vsync),
    .BackPorch    (BackPorch),
    .ActiveVideo  (ActiveVideo),
    .TotalLines   (TotalLines),
    .SyncLines    (SyncLines),
    .yposition    (yposition),
    .ActiveLine   (ActiveLine),
    .Locked       (Locked),
    .FrameStart   (FrameStart)
`ifdef VSYNC_DECODER_ERRCNT_EN
    ,
    .LockLossCount(LockLossCount)
`endif
  );

  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_errs   = 0;
  logic lock_at_fall;
  int   fs_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive on the falling edge, then sample just after the rising edge.
  task automatic cyc(input logic h, input logic v);
    @(negedge CLK);
    hsync = h;
    vsync = v;
    @(posedge CLK);
    #1;
    if (FrameStart) fs_cnt++;
  endtask

  // One frame of 'lines' 4-clock lines. hsync is low on clock 0 of each line. vsync goes
  // low at clock 'off' of line 0 and stays low for 'sync' lines.
  // With BackPorch=3, ActiveVideo=10: region count at line k is k-sync, so the active
  // lines are k = sync+3 .. sync+12, with yposition = k-sync-3.
  task automatic run_frame(input int lines, input int sync, input int off,
                           input bit chk_act, input string tag);
    fs_cnt = 0;
    for (int k = 0; k < lines; k++) begin
      for (int c = 0; c < 4; c++) begin
        int pos;
        pos = k * 4 + c;
        cyc(c != 0, !((pos >= off) && (pos < sync * 4 + off)));
        if (pos == off) lock_at_fall = Locked;
        if (chk_act && c == 3) begin
          bit act;
          act = (k >= sync) && (k - sync >= 3) && (k - sync < 13);
          chk({tag, "_act"}, ActiveLine, act);
          chk({tag, "_ypos"}, yposition, act ? (k - sync - 3) : 0);
        end
      end
    end
  endtask

  task automatic run_lines_vs_high(input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 4; c++) cyc(c != 0, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET       = 1'b1;
    hsync       = 1'b1;
    vsync       = 1'b1;
    BackPorch   = 10'd3;
    ActiveVideo = 10'd10;
    repeat (3) cyc(1'b1, 1'b1);
    RESET = 1'b0;
    cyc(1'b1, 1'b1);

    chk("rst_locked", Locked, 0);
    chk("rst_total", TotalLines, 0);
    chk("rst_sync", SyncLines, 0);
    chk("rst_act", ActiveLine, 0);
    chk("rst_ypos", yposition, 0);
    chk("rst_fs", FrameStart, 0);

    // Steady 17-line frames: lock on the 3rd vsync fall.
    run_frame(17, 2, 2, 0, "a1");
    chk("a1_lock", lock_at_fall, 0);
    run_frame(17, 2, 2, 0, "a2");
    chk("a2_lock", lock_at_fall, 0);
    run_frame(17, 2, 2, 1, "a3");
    chk("a3_lock", lock_at_fall, 1);
    chk("a3_total", TotalLines, 17);
    chk("a3_sync", SyncLines, 2);
    chk("a3_fs", fs_cnt, 1);
    run_frame(17, 2, 2, 1, "a4");
    chk("a4_fs", fs_cnt, 1);

    // One 18-line frame breaks lock; the next one relocks at 18.
    run_frame(18, 2, 2, 0, "b1");
    run_frame(18, 2, 2, 0, "b2");
    chk("b2_lock", lock_at_fall, 0);
    chk("b2_total_held", TotalLines, 17);
    run_frame(18, 2, 2, 0, "b3");
    chk("b3_lock", lock_at_fall, 1);
    chk("b3_total", TotalLines, 18);
`ifdef VSYNC_DECODER_ERRCNT_EN
    chk("b3_llc", LockLossCount, 1);
`endif

    // vsync falls together with hsync: the coincident tick counts in the ending frame.
    run_frame(17, 2, 0, 0, "c1");
    run_frame(17, 2, 0, 0, "c2");
    chk("c2_lock", lock_at_fall, 0);
    run_frame(17, 2, 0, 1, "c3");
    chk("c3_lock", lock_at_fall, 1);
    chk("c3_total", TotalLines, 17);
    chk("c3_sync", SyncLines, 2);
    chk("c3_fs", fs_cnt, 1);

    // The sync width changes from 2 to 3 lines at the same period.
    run_frame(17, 3, 0, 0, "d1");
    run_frame(17, 3, 0, 0, "d2");
    chk("d2_lock", lock_at_fall, 0);
    chk("d2_sync_held", SyncLines, 2);
    run_frame(17, 3, 0, 1, "d3");
    chk("d3_lock", lock_at_fall, 1);
    chk("d3_sync", SyncLines, 3);
    chk("d3_total", TotalLines, 17);
`ifdef VSYNC_DECODER_ERRCNT_EN
    chk("d3_llc", LockLossCount, 3);
`endif

    // vsync stays high: lc is 16 after d3, so it reaches 1023 during the 1007th extra line.
    run_lines_vs_high(1000);
    chk("e_lock_before_to", Locked, 1);
    run_lines_vs_high(10);
    chk("e_lock_after_to", Locked, 0);
    chk("e_act", ActiveLine, 0);
    chk("e_ypos", yposition, 0);
    chk("e_total_held", TotalLines, 17);
`ifdef VSYNC_DECODER_ERRCNT_EN
    chk("e_llc", LockLossCount, 4);
`endif

    // Recover from SEARCH, then reset for one clock mid-frame.
    run_frame(17, 2, 0, 0, "f1");
    run_frame(17, 2, 0, 0, "f2");
    chk("f2_lock", lock_at_fall, 0);
    run_frame(17, 2, 0, 0, "f3");
    chk("f3_lock", lock_at_fall, 1);
    RESET = 1'b1;
    cyc(1'b0, 1'b1);
    RESET = 1'b0;
    chk("r_locked", Locked, 0);
    chk("r_total", TotalLines, 0);
    chk("r_sync", SyncLines, 0);
    chk("r_act", ActiveLine, 0);
    chk("r_ypos", yposition, 0);
    chk("r_fs", FrameStart, 0);
`ifdef VSYNC_DECODER_ERRCNT_EN
    chk("r_llc", LockLossCount, 0);
`endif
    run_frame(17, 2, 0, 0, "g1");
    chk("g1_lock", lock_at_fall, 0);
    run_frame(17, 2, 0, 0, "g2");
    chk("g2_lock", lock_at_fall, 0);
    run_frame(17, 2, 0, 0, "g3");
    chk("g3_lock", lock_at_fall, 1);
    chk("g3_total", TotalLines, 17);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
